// File: rtl/mmu_cache_if.sv
// External memory bus between mmu_cache (master) and the memory system (slave).
// Request/grant for the address phase, rvalid for returned read data.
interface mmu_cache_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mmu_cache.sv
// Direct-mapped I-cache and write-through D-cache with per-thread limit checks
// and one shared memory bus. Define MMU_STATS_EN to add hit/miss counters.
module mmu_cache #(
   parameter int IDX_W = 6,
   parameter int NTRD  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   input  logic        i_rd,
   input  logic [2:0]  i_trd,
   output logic [31:0] i_rd_data,
   output logic        i_miss,
   output logic        i_segfault,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wr_data,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [2:0]  d_trd,
   output logic [31:0] d_rd_data,
   output logic        d_miss,
   output logic        d_segfault,
   input  logic        cfg_wr,
   input  logic [2:0]  cfg_trd,
   input  logic [31:0] cfg_limit,
   mmu_cache_if.master bus
`ifdef MMU_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [31:0] i_hit_cnt,
   output logic [31:0] i_miss_cnt,
   output logic [31:0] d_hit_cnt,
   output logic [31:0] d_miss_cnt
`endif
);
   localparam int NL    = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [2:0] {IDLE, D_RD, D_WT, W_REQ, I_RD, I_WT} state_t;

   logic [31:0]      r_ic_data [NL];
   logic [TAG_W-1:0] r_ic_tag  [NL];
   logic [NL-1:0]    r_ic_valid;
   logic [31:0]      r_dc_data [NL];
   logic [TAG_W-1:0] r_dc_tag  [NL];
   logic [NL-1:0]    r_dc_valid;
   logic [31:0]      r_limit   [NTRD];

   state_t      r_state, w_next;
   logic [31:0] r_addr, r_wdata;
   logic        r_wr_done;

   logic [IDX_W-1:0] w_i_idx, w_d_idx, w_f_idx;
   logic [TAG_W-1:0] w_i_tag, w_d_tag, w_f_tag;
   logic w_i_seg, w_i_hit, w_d_seg, w_d_hit, w_f_dhit;
   logic w_d_wr_go, w_d_rd_miss;
   logic w_req, w_we, w_fill_i, w_fill_d, w_st_upd, w_wr_ack;
   logic w_unused;

   assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

   assign w_i_idx = i_addr[IDX_W+1:2];
   assign w_i_tag = i_addr[31:IDX_W+2];
   assign w_d_idx = d_addr[IDX_W+1:2];
   assign w_d_tag = d_addr[31:IDX_W+2];
   // The fill/store target comes from the latched bus address, not the live core ports.
   assign w_f_idx = r_addr[IDX_W+1:2];
   assign w_f_tag = r_addr[31:IDX_W+2];

   assign w_i_seg  = i_rd && (i_addr >= r_limit[i_trd]);
   assign w_i_hit  = r_ic_valid[w_i_idx] && (r_ic_tag[w_i_idx] == w_i_tag);
   assign w_d_seg  = (d_rd || d_wr) && (d_addr >= r_limit[d_trd]);
   assign w_d_hit  = r_dc_valid[w_d_idx] && (r_dc_tag[w_d_idx] == w_d_tag);
   assign w_f_dhit = r_dc_valid[w_f_idx] && (r_dc_tag[w_f_idx] == w_f_tag);

   assign w_d_wr_go   = d_wr && !w_d_seg && !r_wr_done;
   assign w_d_rd_miss = d_rd && !d_wr && !w_d_seg && !w_d_hit;

   assign i_segfault = w_i_seg;
   assign i_miss     = i_rd && !w_i_seg && !w_i_hit;
   assign i_rd_data  = w_i_hit ? r_ic_data[w_i_idx] : '0;
   assign d_segfault = w_d_seg;
   assign d_miss     = w_d_wr_go || w_d_rd_miss;
   assign d_rd_data  = w_d_hit ? r_dc_data[w_d_idx] : '0;

   assign bus.mem_req   = w_req;
   assign bus.mem_we    = w_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      w_next   = r_state;
      w_req    = 1'b0;
      w_we     = 1'b0;
      w_fill_i = 1'b0;
      w_fill_d = 1'b0;
      w_st_upd = 1'b0;
      w_wr_ack = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_d_wr_go)        w_next = W_REQ;
            else if (w_d_rd_miss) w_next = D_RD;
            else if (i_miss)      w_next = I_RD;
         end
         D_RD, I_RD: begin
            w_req = 1'b1;
            if (bus.mem_gnt) w_next = (r_state == D_RD) ? D_WT : I_WT;
         end
         W_REQ: begin
            w_req = 1'b1;
            w_we  = 1'b1;
            if (bus.mem_gnt) begin
               w_wr_ack = 1'b1;
               w_st_upd = w_f_dhit;
               w_next   = IDLE;
            end
         end
         D_WT, I_WT: begin
            if (bus.mem_rvalid) begin
               w_fill_d = (r_state == D_WT);
               w_fill_i = (r_state == I_WT);
               w_next   = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
      if (rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wr_done  <= 1'b0;
         r_ic_valid <= '0;
         r_dc_valid <= '0;
         for (int t = 0; t < NTRD; t++) r_limit[t] <= '1;
      end else begin
         r_state   <= w_next;
         r_wr_done <= w_wr_ack;
         if (r_state == IDLE && w_next != IDLE) begin
            r_addr  <= (w_next == I_RD) ? {i_addr[31:2], 2'b00} : {d_addr[31:2], 2'b00};
            r_wdata <= (w_next == W_REQ) ? d_wr_data : '0;
         end
         if (cfg_wr)   r_limit[cfg_trd]    <= cfg_limit;
         if (w_fill_i) r_ic_valid[w_f_idx] <= 1'b1;
         if (w_fill_d) r_dc_valid[w_f_idx] <= 1'b1;
      end
   end

   // NOTE: line data and tags have no reset; the cleared valid bits make them unobservable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_i) begin
            r_ic_data[w_f_idx] <= bus.mem_rdata;
            r_ic_tag[w_f_idx]  <= w_f_tag;
         end
         if (w_fill_d) begin
            r_dc_data[w_f_idx] <= bus.mem_rdata;
            r_dc_tag[w_f_idx]  <= w_f_tag;
         end else if (w_st_upd) begin
            r_dc_data[w_f_idx] <= r_wdata;
         end
      end
   end

`ifdef MMU_STATS_EN
   logic r_i_held, r_d_held;
   logic w_i_new, w_d_new;

   // An access held across a miss is counted once, on the cycle it first appears.
   assign w_i_new = i_rd && !w_i_seg && !r_i_held;
   assign w_d_new = (d_rd || d_wr) && !w_d_seg && !r_d_held;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_i_held <= 1'b0;
         r_d_held <= 1'b0;
      end else begin
         r_i_held <= i_miss;
         r_d_held <= d_miss;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         i_hit_cnt  <= '0;
         i_miss_cnt <= '0;
         d_hit_cnt  <= '0;
         d_miss_cnt <= '0;
      end else begin
         if (w_i_new &&  w_i_hit) i_hit_cnt  <= sat_inc(i_hit_cnt);
         if (w_i_new && !w_i_hit) i_miss_cnt <= sat_inc(i_miss_cnt);
         if (w_d_new &&  w_d_hit) d_hit_cnt  <= sat_inc(d_hit_cnt);
         if (w_d_new && !w_d_hit) d_miss_cnt <= sat_inc(d_miss_cnt);
      end
   end
`endif
endmodule
